// File: rtl/phys_reg_alloc_pkg.sv
// Shared rename-stage types and helpers (package rv32i_types).
//
// Holds the machine-width constants used by the free-list allocator, the
// physical register typedef and the free-list pointer typedef (index plus
// wrap bit). The helpers do modulo-DEPTH index arithmetic, so the free list
// works even when DEPTH = NUM_PHYS_REGS - 32 is not a power of two.
package rv32i_types;

  localparam int SS_FACTOR          = 2;
  localparam int SS_FACTOR_BITS     = 1;
  localparam int NUM_PHYS_REGS      = 64;
  localparam int NUM_PHYS_REGS_BITS = $clog2(NUM_PHYS_REGS);

  // The free list holds every register that is not architecturally mapped:
  // 32 are always mapped, so the rest can be free at once.
  localparam int FL_DEPTH    = NUM_PHYS_REGS - 32;
  localparam int FL_IDX_BITS = $clog2(FL_DEPTH);

  typedef logic [NUM_PHYS_REGS_BITS-1:0] phys_reg;
  typedef logic [SS_FACTOR_BITS:0]       slot_cnt_t;
  typedef logic [FL_IDX_BITS:0]          fl_cnt_t;

  typedef struct packed {
    logic                   wrap;
    logic [FL_IDX_BITS-1:0] idx;
  } free_ptr_t;

  localparam fl_cnt_t FL_DEPTH_CNT = fl_cnt_t'(FL_DEPTH);

  function automatic fl_cnt_t widen_cnt(input slot_cnt_t n);
    return fl_cnt_t'(n);
  endfunction

  // idx + n modulo DEPTH; n never exceeds DEPTH, so one correction suffices.
  function automatic logic [FL_IDX_BITS-1:0] idx_add(input logic [FL_IDX_BITS-1:0] idx,
                                                     input slot_cnt_t n);
    fl_cnt_t s;
    s = {1'b0, idx} + widen_cnt(n);
    if (s >= FL_DEPTH_CNT) s = s - FL_DEPTH_CNT;
    return s[FL_IDX_BITS-1:0];
  endfunction

  // Pointer advance: the wrap bit toggles whenever the index passes DEPTH.
  function automatic free_ptr_t ptr_add(input free_ptr_t p, input slot_cnt_t n);
    fl_cnt_t   s;
    free_ptr_t r;
    s = {1'b0, p.idx} + widen_cnt(n);
    if (s >= FL_DEPTH_CNT) begin
      s      = s - FL_DEPTH_CNT;
      r.wrap = ~p.wrap;
    end else begin
      r.wrap = p.wrap;
    end
    r.idx = s[FL_IDX_BITS-1:0];
    return r;
  endfunction

  // Occupancy = tail - head, modulo the doubled pointer space.
  function automatic fl_cnt_t free_count(input free_ptr_t tail, input free_ptr_t head);
    if (tail.wrap == head.wrap) return {1'b0, tail.idx} - {1'b0, head.idx};
    else                        return FL_DEPTH_CNT - {1'b0, head.idx} + {1'b0, tail.idx};
  endfunction

endpackage

// File: rtl/phys_reg_alloc_ptr.sv
// free_list_ptr: one free-list pointer register (index + wrap bit).
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   inc       - amount to advance this cycle (0..2*SS-1)
//   load      - overrides the advance: ptr <= load_ptr with the wrap bit inverted
//   load_ptr  - pointer to copy on load
//   ptr       - current pointer value
// RST_WRAP selects the wrap bit at reset (index always resets to 0).
module free_list_ptr
  import rv32i_types::*;
#(
  parameter logic RST_WRAP = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  input  slot_cnt_t inc,
  input  logic      load,
  input  free_ptr_t load_ptr,
  output free_ptr_t ptr
);

  free_ptr_t ptr_next;

  always_comb begin
    ptr_next = ptr_add(ptr, inc);
    if (load) begin
      ptr_next.wrap = ~load_ptr.wrap;
      ptr_next.idx  = load_ptr.idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr.wrap <= RST_WRAP;
      ptr.idx  <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/phys_reg_alloc.sv
// phys_reg_alloc: physical-register allocator / free-list controller.
//
// Build option: define FREE_LIST_CHECK_EN to enable the sticky protocol
// error flag (err) and matching simulation assertions; otherwise err = 0.
//
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   mispredict  - flush; the free list becomes full again (pushes still land)
//   alloc_req   - per-slot request (slot has a real destination register)
//   alloc_pd    - allocated register per slot, 0 for unrequested slots
//   alloc_ok    - every requested slot can be served this cycle
//   alloc_fire  - dispatch consumes the allocation
//   push_cnt    - number of freed registers, packed from slot 0
//   push_pd     - freed registers from the retirement map
//   free_cnt    - free entries at the start of the cycle
//   err         - sticky protocol error
//
// Handshake: alloc_ok is the ready and alloc_req the valid; a transfer of
// popcount(alloc_req) registers happens on a clock edge where alloc_fire
// and alloc_ok are both high and mispredict is low. alloc_fire must only be
// raised when alloc_ok is high. Pushes have no back-pressure and are always
// taken; pushed registers become allocatable on the following cycle.
module phys_reg_alloc
  import rv32i_types::*;
(
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             mispredict,
  input  logic [SS_FACTOR-1:0]                             alloc_req,
  output logic [SS_FACTOR-1:0][NUM_PHYS_REGS_BITS-1:0]     alloc_pd,
  output logic                                             alloc_ok,
  input  logic                                             alloc_fire,
  input  logic [SS_FACTOR_BITS:0]                          push_cnt,
  input  logic [SS_FACTOR-1:0][NUM_PHYS_REGS_BITS-1:0]     push_pd,
  output logic [FL_IDX_BITS:0]                             free_cnt,
  output logic                                             err
);

  phys_reg   entries [FL_DEPTH];
  free_ptr_t head;
  free_ptr_t tail;
  free_ptr_t tail_next;
  slot_cnt_t req_cnt;
  slot_cnt_t pop_cnt;
  logic      do_pop;

  assign free_cnt = free_count(tail, head);

  // Requesting slots take consecutive entries starting at head, in slot order.
  always_comb begin
    req_cnt  = '0;
    alloc_pd = '0;
    for (int i = 0; i < SS_FACTOR; i++) begin
      if (alloc_req[i]) begin
        alloc_pd[i] = entries[idx_add(head.idx, req_cnt)];
        req_cnt     = req_cnt + slot_cnt_t'(1);
      end
    end
  end

  assign alloc_ok  = (widen_cnt(req_cnt) <= free_cnt);
  assign do_pop    = alloc_fire && alloc_ok && !mispredict;
  assign pop_cnt   = do_pop ? req_cnt : '0;
  assign tail_next = ptr_add(tail, push_cnt);

  // On mispredict head jumps to the post-push tail with the wrap bit flipped:
  // the list is full again, and the slots behind the new head still hold the
  // speculatively allocated registers that the flush has just released.
  free_list_ptr #(.RST_WRAP(1'b0)) u_head (
    .clk      (clk),
    .rst      (rst),
    .inc      (pop_cnt),
    .load     (mispredict),
    .load_ptr (tail_next),
    .ptr      (head)
  );

  free_list_ptr #(.RST_WRAP(1'b1)) u_tail (
    .clk      (clk),
    .rst      (rst),
    .inc      (push_cnt),
    .load     (1'b0),
    .load_ptr (tail),
    .ptr      (tail)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) entries[i] <= phys_reg'(32 + i);
    end else begin
      for (int j = 0; j < SS_FACTOR; j++) begin
        if (slot_cnt_t'(j) < push_cnt) entries[idx_add(tail.idx, slot_cnt_t'(j))] <= push_pd[j];
      end
    end
  end

`ifdef FREE_LIST_CHECK_EN
  localparam int XW = FL_IDX_BITS + 2;

  logic [XW-1:0] cnt_after;
  logic          push_overflow;
  logic          push_zero;
  logic          bad_fire;
  logic          bad_cnt;
  logic          err_q;

  // Extra bit so an over-full result is visible rather than wrapping.
  assign cnt_after     = XW'(free_cnt) - XW'(pop_cnt) + XW'(push_cnt);
  assign push_overflow = (cnt_after > XW'(FL_DEPTH));
  assign bad_fire      = alloc_fire && !alloc_ok;
  assign bad_cnt       = (push_cnt > slot_cnt_t'(SS_FACTOR));

  always_comb begin
    push_zero = 1'b0;
    for (int j = 0; j < SS_FACTOR; j++) begin
      if ((slot_cnt_t'(j) < push_cnt) && (push_pd[j] == '0)) push_zero = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | push_overflow | push_zero | bad_fire | bad_cnt;
  end

  assign err = err_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !push_overflow)
    else $error("free list push overflow");
  a_no_zero_push: assert property (@(posedge clk) disable iff (rst) !push_zero)
    else $error("free list push of p0");
  a_fire_ok: assert property (@(posedge clk) disable iff (rst) !bad_fire)
    else $error("alloc_fire without alloc_ok");
  a_push_cnt: assert property (@(posedge clk) disable iff (rst) !bad_cnt)
    else $error("push_cnt above slot count");
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_alloc.sv
// Directed bench for phys_reg_alloc (NUM_PHYS = 64, SS = 2, DEPTH = 32).
module tb_phys_reg_alloc;
  import rv32i_types::*;

  logic                                         clk;
  logic                                         rst;
  logic                                         mispredict;
  logic [SS_FACTOR-1:0]                         alloc_req;
  logic [SS_FACTOR-1:0][NUM_PHYS_REGS_BITS-1:0] alloc_pd;
  logic                                         alloc_ok;
  logic                                         alloc_fire;
  logic [SS_FACTOR_BITS:0]                      push_cnt;
  logic [SS_FACTOR-1:0][NUM_PHYS_REGS_BITS-1:0] push_pd;
  logic [FL_IDX_BITS:0]                         free_cnt;
  logic                                         err;

  int vectors;
  int miscompares;

  phys_reg_alloc dut (
    .clk        (clk),
    .rst        (rst),
    .mispredict (mispredict),
    .alloc_req  (alloc_req),
    .alloc_pd   (alloc_pd),
    .alloc_ok   (alloc_ok),
    .alloc_fire (alloc_fire),
    .push_cnt   (push_cnt),
    .push_pd    (push_pd),
    .free_cnt   (free_cnt),
    .err        (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mispredict = 1'b0;
    alloc_req  = '0;
    alloc_fire = 1'b0;
    push_cnt   = '0;
    push_pd    = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
  endtask

  // ---------------- driver ----------------
  // Drive one cycle's inputs and let combinational outputs settle.
  task automatic drive(input logic [1:0] req, input logic fire, input logic mp,
                       input logic [1:0] pcnt, input logic [5:0] p0, input logic [5:0] p1);
    alloc_req  = req;
    alloc_fire = fire;
    mispredict = mp;
    push_cnt   = pcnt;
    push_pd[0] = p0;
    push_pd[1] = p1;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    vectors++;
    if (free_cnt !== 6'd32) begin
      miscompares++; $display("FAIL reset_free_cnt: got %0d want 32", free_cnt);
    end
    vectors++;
    if (err !== 1'b0) begin
      miscompares++; $display("FAIL reset_err: got %b want 0", err);
    end
    drive(2'b00, 1'b0, 1'b0, 2'd0, 6'd0, 6'd0);
    vectors++;
    if (alloc_pd !== 12'd0 || alloc_ok !== 1'b1) begin
      miscompares++; $display("FAIL reset_idle_alloc: got pd=%h ok=%b want pd=0 ok=1", alloc_pd, alloc_ok);
    end
  endtask

  task automatic test_alloc_pair();
    drive(2'b11, 1'b1, 1'b0, 2'd0, 6'd0, 6'd0);
    vectors++;
    if (alloc_pd[0] !== 6'd32 || alloc_pd[1] !== 6'd33 || alloc_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL alloc_pair: got %0d,%0d ok=%b want 32,33 ok=1", alloc_pd[0], alloc_pd[1], alloc_ok);
    end
    cycle();
    drive(2'b00, 1'b0, 1'b0, 2'd0, 6'd0, 6'd0);
    vectors++;
    if (free_cnt !== 6'd30) begin
      miscompares++; $display("FAIL alloc_pair_cnt: got %0d want 30", free_cnt);
    end
  endtask

  task automatic test_alloc_slot1();
    drive(2'b10, 1'b1, 1'b0, 2'd0, 6'd0, 6'd0);
    vectors++;
    if (alloc_pd[0] !== 6'd0 || alloc_pd[1] !== 6'd34) begin
      miscompares++; $display("FAIL alloc_slot1: got %0d,%0d want 0,34", alloc_pd[0], alloc_pd[1]);
    end
    cycle();
    drive(2'b00, 1'b0, 1'b0, 2'd0, 6'd0, 6'd0);
    vectors++;
    if (free_cnt !== 6'd29) begin
      miscompares++; $display("FAIL alloc_slot1_cnt: got %0d want 29", free_cnt);
    end
  endtask

  // Drain the remaining 29 entries (35..63), then hit the empty boundary.
  task automatic test_exhaust();
    logic [5:0] e0, e1;
    for (int c = 0; c < 14; c++) begin
      e0 = 6'(35 + 2 * c);
      e1 = 6'(36 + 2 * c);
      drive(2'b11, 1'b1, 1'b0, 2'd0, 6'd0, 6'd0);
      vectors++;
      if (alloc_pd[0] !== e0 || alloc_pd[1] !== e1 || alloc_ok !== 1'b1) begin
        miscompares++;
        $display("FAIL drain_%0d: got %0d,%0d ok=%b want %0d,%0d ok=1", c, alloc_pd[0], alloc_pd[1], alloc_ok, e0, e1);
      end
      cycle();
    end
    drive(2'b01, 1'b1, 1'b0, 2'd0, 6'd0, 6'd0);
    vectors++;
    if (alloc_pd[0] !== 6'd63 || alloc_ok !== 1'b1) begin
      miscompares++; $display("FAIL drain_last: got %0d ok=%b want 63 ok=1", alloc_pd[0], alloc_ok);
    end
    cycle();
    // Empty: request refused, and a same-cycle push does not bypass.
    drive(2'b01, 1'b0, 1'b0, 2'd1, 6'd5, 6'd0);
    vectors++;
    if (free_cnt !== 6'd0 || alloc_ok !== 1'b0) begin
      miscompares++; $display("FAIL empty: got cnt=%0d ok=%b want cnt=0 ok=0", free_cnt, alloc_ok);
    end
    cycle();
    drive(2'b01, 1'b1, 1'b0, 2'd0, 6'd0, 6'd0);
    vectors++;
    if (alloc_pd[0] !== 6'd5 || alloc_ok !== 1'b1 || free_cnt !== 6'd1) begin
      miscompares++;
      $display("FAIL after_push: got pd=%0d ok=%b cnt=%0d want 5 1 1", alloc_pd[0], alloc_ok, free_cnt);
    end
    cycle();
    drive(2'b00, 1'b0, 1'b0, 2'd0, 6'd0, 6'd0);
    vectors++;
    if (free_cnt !== 6'd0) begin
      miscompares++; $display("FAIL after_pop_push: got %0d want 0", free_cnt);
    end
  endtask

  // Pop 3, mispredict (pop requested but suppressed): the list is full again
  // and restarts at the reset tail, so 32.. comes out first.
  task automatic test_mispredict();
    apply_reset();
    drive(2'b11, 1'b1, 1'b0, 2'd0, 6'd0, 6'd0);
    cycle();
    drive(2'b01, 1'b1, 1'b0, 2'd0, 6'd0, 6'd0);
    vectors++;
    if (alloc_pd[0] !== 6'd34) begin
      miscompares++; $display("FAIL mp_pre_pop: got %0d want 34", alloc_pd[0]);
    end
    cycle();
    drive(2'b11, 1'b1, 1'b1, 2'd0, 6'd0, 6'd0);
    cycle();
    drive(2'b11, 1'b1, 1'b0, 2'd0, 6'd0, 6'd0);
    vectors++;
    if (free_cnt !== 6'd32 || alloc_pd[0] !== 6'd32 || alloc_pd[1] !== 6'd33) begin
      miscompares++;
      $display("FAIL mp_restore: got cnt=%0d pd=%0d,%0d want 32 32,33", free_cnt, alloc_pd[0], alloc_pd[1]);
    end
    cycle();
    drive(2'b00, 1'b0, 1'b0, 2'd0, 6'd0, 6'd0);
    vectors++;
    if (free_cnt !== 6'd30) begin
      miscompares++; $display("FAIL mp_after_pop: got %0d want 30", free_cnt);
    end
  endtask

  // Mispredict with two pushes: pushes land at tail 0,1; head restarts at 2.
  task automatic test_mispredict_push();
    logic [5:0] e0, e1;
    apply_reset();
    drive(2'b11, 1'b1, 1'b0, 2'd0, 6'd0, 6'd0);
    cycle();
    cycle();
    drive(2'b00, 1'b0, 1'b1, 2'd2, 6'd7, 6'd9);
    cycle();
    drive(2'b00, 1'b0, 1'b0, 2'd0, 6'd0, 6'd0);
    vectors++;
    if (free_cnt !== 6'd32) begin
      miscompares++; $display("FAIL mp_push_cnt: got %0d want 32", free_cnt);
    end
    for (int c = 0; c < 15; c++) begin
      e0 = 6'(34 + 2 * c);
      e1 = 6'(35 + 2 * c);
      drive(2'b11, 1'b1, 1'b0, 2'd0, 6'd0, 6'd0);
      vectors++;
      if (alloc_pd[0] !== e0 || alloc_pd[1] !== e1) begin
        miscompares++;
        $display("FAIL mp_push_drain_%0d: got %0d,%0d want %0d,%0d", c, alloc_pd[0], alloc_pd[1], e0, e1);
      end
      cycle();
    end
    drive(2'b11, 1'b1, 1'b0, 2'd0, 6'd0, 6'd0);
    vectors++;
    if (alloc_pd[0] !== 6'd7 || alloc_pd[1] !== 6'd9 || alloc_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL mp_push_wrap: got %0d,%0d ok=%b want 7,9 ok=1", alloc_pd[0], alloc_pd[1], alloc_ok);
    end
    cycle();
    drive(2'b00, 1'b0, 1'b0, 2'd0, 6'd0, 6'd0);
    vectors++;
    if (free_cnt !== 6'd0) begin
      miscompares++; $display("FAIL mp_push_empty: got %0d want 0", free_cnt);
    end
  endtask

  // Pop and push in the same cycle: both take effect, no bypass.
  task automatic test_back_to_back();
    apply_reset();
    drive(2'b11, 1'b1, 1'b0, 2'd0, 6'd0, 6'd0);
    cycle();
    drive(2'b11, 1'b1, 1'b0, 2'd2, 6'd20, 6'd21);
    vectors++;
    if (alloc_pd[0] !== 6'd34 || alloc_pd[1] !== 6'd35) begin
      miscompares++; $display("FAIL b2b_pop: got %0d,%0d want 34,35", alloc_pd[0], alloc_pd[1]);
    end
    cycle();
    drive(2'b00, 1'b0, 1'b0, 2'd0, 6'd0, 6'd0);
    vectors++;
    if (free_cnt !== 6'd30) begin
      miscompares++; $display("FAIL b2b_cnt: got %0d want 30", free_cnt);
    end
  endtask

  // Push while full: err behaviour depends on the build option.
  task automatic test_err();
    logic exp_err;
`ifdef FREE_LIST_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    apply_reset();
    drive(2'b00, 1'b0, 1'b0, 2'd1, 6'd12, 6'd0);
    cycle();
    drive(2'b00, 1'b0, 1'b0, 2'd0, 6'd0, 6'd0);
    vectors++;
    if (err !== exp_err) begin
      miscompares++; $display("FAIL err_set: got %b want %b", err, exp_err);
    end
    cycle();
    cycle();
    vectors++;
    if (err !== exp_err) begin
      miscompares++; $display("FAIL err_hold: got %b want %b", err, exp_err);
    end
    apply_reset();
    vectors++;
    if (err !== 1'b0 || free_cnt !== 6'd32) begin
      miscompares++; $display("FAIL err_clear: got err=%b cnt=%0d want 0 32", err, free_cnt);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    idle_inputs();
    test_reset();
    test_alloc_pair();
    test_alloc_slot1();
    test_exhaust();
    test_mispredict();
    test_mispredict_push();
    test_back_to_back();
    test_err();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
